// File: rtl/dbgcmd.sv
// dbgcmd: UART-driven debug command parser.
//
// A host sends ASCII lines over an 8N1 serial link:
//   "w<addr> <data>\r"  -> write command (cmd_we pulse)
//   "r<addr>\r"         -> read command  (cmd_re pulse)
// Addresses and data are 1+ lowercase hex digits; only the last four are
// kept, and shorter values are zero-extended. LF is ignored everywhere.
// A malformed line produces a cmd_err pulse once its CR arrives.
//
// Parameters:
//   CLK_FRQ    clock frequency in Hz
//   BAUD_RATE  serial bit rate; bit period DIV = CLK_FRQ / BAUD_RATE clocks
//
// Configuration macro:
//   DBGCMD_UPPER_EN  when defined, 'W', 'R' and 'A'-'F' are accepted like
//                    their lowercase forms; otherwise they are invalid bytes.
//
// Ports:
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   rx_in           UART serial input, idle high
//   cmd_addr        address of the last accepted command
//   cmd_wdata       data of the last accepted write command
//   cmd_we          one-cycle pulse, write command accepted
//   cmd_re          one-cycle pulse, read command accepted
//   cmd_err         one-cycle pulse, malformed line terminated
//   o_dbg_rx_state  receiver FSM state (debug)
//   o_dbg_ps_state  parser FSM state (debug)
//
// Handshake: there is no back-pressure. A command is presented by a single
// cycle pulse on cmd_we/cmd_re; cmd_addr/cmd_wdata are valid from that
// cycle on and hold until the next accepted command.
module dbgcmd #(
  parameter int CLK_FRQ   = 27_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_in,
  output logic [15:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  output logic        cmd_we,
  output logic        cmd_re,
  output logic        cmd_err,
  output logic [1:0]  o_dbg_rx_state,
  output logic [1:0]  o_dbg_ps_state
);

  localparam int DIV  = CLK_FRQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {PS_IDLE, PS_ADDR, PS_DATA, PS_ERR} ps_state_t;

  // ---------------- synchronizer ----------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   r_rx_state, w_rx_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_byte_valid;
  logic        r_frame_err;
  logic        w_cnt_half, w_cnt_full;

  assign w_cnt_half = (r_cnt == CW'(HALF - 1));
  assign w_cnt_full = (r_cnt == CW'(DIV - 1));

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START;
      // Mid-start recheck: a line that is high again was only a glitch.
      RX_START: if (w_cnt_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_cnt_full && r_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_cnt_full) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state   <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      // Counter restarts at the start mid-point and at every bit sample, so
      // all later samples land on bit centres.
      if (r_rx_state == RX_IDLE || (r_rx_state == RX_START && w_cnt_half) || w_cnt_full)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_rx_state == RX_START)
        r_bit <= '0;
      else if (r_rx_state == RX_DATA && w_cnt_full)
        r_bit <= r_bit + 1'b1;
      if (r_rx_state == RX_DATA && w_cnt_full)
        r_shift <= {r_rx_sync, r_shift[7:1]};
      r_byte_valid <= (r_rx_state == RX_STOP) && w_cnt_full && r_rx_sync;
      r_frame_err  <= (r_rx_state == RX_STOP) && w_cnt_full && !r_rx_sync;
    end
  end

  // ---------------- byte classification ----------------
  logic       w_is_hex, w_is_w, w_is_r;
  logic [3:0] w_hex_val;

  always_comb begin
    w_is_hex  = 1'b0;
    w_hex_val = '0;
    if (r_shift >= 8'h30 && r_shift <= 8'h39) begin
      w_is_hex  = 1'b1;
      w_hex_val = r_shift[3:0];
    end else if (r_shift >= 8'h61 && r_shift <= 8'h66) begin
      w_is_hex  = 1'b1;
      w_hex_val = r_shift[3:0] + 4'd9;
    end
`ifdef DBGCMD_UPPER_EN
    else if (r_shift >= 8'h41 && r_shift <= 8'h46) begin
      w_is_hex  = 1'b1;
      w_hex_val = r_shift[3:0] + 4'd9;
    end
    w_is_w = (r_shift == 8'h77) || (r_shift == 8'h57);
    w_is_r = (r_shift == 8'h72) || (r_shift == 8'h52);
`else
    w_is_w = (r_shift == 8'h77);
    w_is_r = (r_shift == 8'h72);
`endif
  end

  // ---------------- parser ----------------
  ps_state_t   r_ps_state, w_ps_next;
  logic        r_op_write, r_has_digit;
  logic [15:0] r_addr_acc, r_data_acc;
  logic        w_start, w_sh_addr, w_sh_data, w_clr_digit;
  logic        w_fire_we, w_fire_re, w_fire_err;

  always_comb begin
    w_ps_next   = r_ps_state;
    w_start     = 1'b0;
    w_sh_addr   = 1'b0;
    w_sh_data   = 1'b0;
    w_clr_digit = 1'b0;
    w_fire_we   = 1'b0;
    w_fire_re   = 1'b0;
    w_fire_err  = 1'b0;
    if (r_frame_err) begin
      w_ps_next = PS_ERR;
    end else if (r_byte_valid && r_shift != CH_LF) begin
      case (r_ps_state)
        PS_IDLE: begin
          if (w_is_w || w_is_r) begin
            w_ps_next = PS_ADDR;
            w_start   = 1'b1;
          end else if (r_shift != CH_SP && r_shift != CH_CR) begin
            w_ps_next = PS_ERR;
          end
        end
        PS_ADDR: begin
          if (w_is_hex) begin
            w_sh_addr = 1'b1;
          end else if (r_shift == CH_SP) begin
            if (r_has_digit) begin
              w_ps_next   = r_op_write ? PS_DATA : PS_ERR;
              w_clr_digit = 1'b1;
            end
          end else if (r_shift == CH_CR) begin
            w_ps_next  = PS_IDLE;
            w_fire_re  = !r_op_write && r_has_digit;
            w_fire_err = !(!r_op_write && r_has_digit);
          end else begin
            w_ps_next = PS_ERR;
          end
        end
        PS_DATA: begin
          if (w_is_hex) begin
            w_sh_data = 1'b1;
          end else if (r_shift == CH_SP) begin
            // A second separator after data digits is not a valid line.
            if (r_has_digit) w_ps_next = PS_ERR;
          end else if (r_shift == CH_CR) begin
            w_ps_next  = PS_IDLE;
            w_fire_we  = r_has_digit;
            w_fire_err = !r_has_digit;
          end else begin
            w_ps_next = PS_ERR;
          end
        end
        PS_ERR: begin
          if (r_shift == CH_CR) begin
            w_ps_next  = PS_IDLE;
            w_fire_err = 1'b1;
          end
        end
        default: w_ps_next = PS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ps_state  <= PS_IDLE;
      r_op_write  <= 1'b0;
      r_has_digit <= 1'b0;
      r_addr_acc  <= '0;
      r_data_acc  <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_we      <= 1'b0;
      cmd_re      <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      r_ps_state <= w_ps_next;
      if (w_start) begin
        r_op_write  <= w_is_w;
        r_addr_acc  <= '0;
        r_data_acc  <= '0;
        r_has_digit <= 1'b0;
      end
      if (w_sh_addr) begin
        r_addr_acc  <= {r_addr_acc[11:0], w_hex_val};
        r_has_digit <= 1'b1;
      end
      if (w_sh_data) begin
        r_data_acc  <= {r_data_acc[11:0], w_hex_val};
        r_has_digit <= 1'b1;
      end
      if (w_clr_digit) r_has_digit <= 1'b0;
      cmd_we  <= w_fire_we;
      cmd_re  <= w_fire_re;
      cmd_err <= w_fire_err;
      if (w_fire_we) begin
        cmd_addr  <= r_addr_acc;
        cmd_wdata <= r_data_acc;
      end
      if (w_fire_re) cmd_addr <= r_addr_acc;
    end
  end

  assign o_dbg_rx_state = r_rx_state;
  assign o_dbg_ps_state = r_ps_state;

endmodule

// File: tb/tb_dbgcmd.sv
// tb_dbgcmd: self-checking bench for dbgcmd.
// Serial lines are driven bit by bit; each expected command pulse is pushed
// as {kind, addr, wdata} before its line is sent and checked by a monitor
// when the DUT pulses. kind: 1 = write, 2 = read, 3 = error.
module tb_dbgcmd;

  localparam int CLK_FRQ   = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DIV       = CLK_FRQ / BAUD_RATE;

  logic        clk;
  logic        reset_n;
  logic        rx_in;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        cmd_we, cmd_re, cmd_err;
  logic [1:0]  dbg_rx, dbg_ps;

  logic [33:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_addr   = '0;
  logic [15:0] m_wdata  = '0;

  dbgcmd #(.CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_in          (rx_in),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_we         (cmd_we),
    .cmd_re         (cmd_re),
    .cmd_err        (cmd_err),
    .o_dbg_rx_state (dbg_rx),
    .o_dbg_ps_state (dbg_ps)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && (cmd_we || cmd_re || cmd_err)) begin
      logic [33:0] e;
      logic [1:0]  kind;
      kind = cmd_we ? 2'd1 : (cmd_re ? 2'd2 : 2'd3);
      checks++;
      if ($countones({cmd_we, cmd_re, cmd_err}) != 1) begin
        failures++;
        $display("FAIL one_hot_pulse we=%0b re=%0b err=%0b", cmd_we, cmd_re, cmd_err);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse kind=%0d addr=%h wdata=%h", kind, cmd_addr, cmd_wdata);
      end else begin
        e = exp_q.pop_front();
        if (kind !== e[33:32]) begin
          failures++;
          $display("FAIL pulse_kind got=%0d exp=%0d", kind, e[33:32]);
        end
        checks++;
        if (cmd_addr !== e[31:16]) begin
          failures++;
          $display("FAIL cmd_addr got=%h exp=%h", cmd_addr, e[31:16]);
        end
        checks++;
        if (cmd_wdata !== e[15:0]) begin
          failures++;
          $display("FAIL cmd_wdata got=%h exp=%h", cmd_wdata, e[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx_in = stop_bit;
    repeat (DIV) @(negedge clk);
    rx_in = 1'b1;
    if (!stop_bit) repeat (DIV) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic send_cr();
    send_byte(8'h0d, 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4 * DIV && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  task automatic push_exp(input logic [1:0] kind);
    exp_q.push_back({kind, m_addr, m_wdata});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rx_in   = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({cmd_addr, cmd_wdata} !== 32'h0 || {cmd_we, cmd_re, cmd_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got addr=%h wdata=%h pulses=%b exp=0", cmd_addr, cmd_wdata,
               {cmd_we, cmd_re, cmd_err});
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (dbg_ps !== 2'd0 || dbg_rx !== 2'd0) begin
      failures++;
      $display("FAIL reset_states got rx=%0d ps=%0d exp=0", dbg_rx, dbg_ps);
    end
  endtask

  task automatic test_write();
    m_addr = 16'h0012; m_wdata = 16'h00ab; push_exp(2'd1);
    send_str("w12 ab"); send_cr();
    m_addr = 16'h3456; m_wdata = 16'habcd; push_exp(2'd1);
    send_str("w123456 9abcd"); send_cr();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL write_missing got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_read();
    m_addr = 16'h1234; push_exp(2'd2);
    send_str("r1234"); send_cr(); send_byte(8'h0a, 1'b1);
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL read_missing got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_errors();
    push_exp(2'd3); send_str("x1"); send_cr();
    push_exp(2'd3); send_str("r");  send_cr();
    push_exp(2'd3); send_str("r12 3"); send_cr();
    push_exp(2'd3); send_str("w12"); send_cr();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL error_missing got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_framing_glitch();
    push_exp(2'd3);
    send_byte("w", 1'b0);
    send_str("12 3"); send_cr();
    wait_drain();
    // Quarter-bit glitch must not create a byte; the next line must parse.
    rx_in = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    m_addr = 16'h0005; push_exp(2'd2);
    send_str("r5"); send_cr();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL framing_glitch_missing got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_upper();
`ifdef DBGCMD_UPPER_EN
    m_addr = 16'h001f; m_wdata = 16'h0000; push_exp(2'd1);
`else
    push_exp(2'd3);
`endif
    send_str("W1F 0"); send_cr();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL upper_missing got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = "2";
    send_str("w1");
    // Start a byte, abandon it after three data bits.
    rx_in = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = b[i];
      repeat (DIV) @(negedge clk);
    end
    reset_n = 1'b0;
    rx_in   = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_addr = '0; m_wdata = '0;
    repeat (2 * DIV) @(negedge clk);
    checks++;
    if (cmd_addr !== 16'h0 || cmd_wdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_clear got addr=%h wdata=%h exp=0", cmd_addr, cmd_wdata);
    end
    send_cr();
    send_cr();
    m_addr = 16'h0007; push_exp(2'd2);
    send_str("r7"); send_cr();
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_missing got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      logic [15:0] a, d;
      int na, nd;
      a  = 16'($urandom_range(0, 65535));
      d  = 16'($urandom_range(0, 65535));
      na = $urandom_range(1, 4);
      nd = $urandom_range(1, 4);
      m_addr = (na == 4) ? a : (a & 16'((32'h1 << (4 * na)) - 1));
      if ($urandom_range(0, 1) == 1) begin
        m_wdata = (nd == 4) ? d : (d & 16'((32'h1 << (4 * nd)) - 1));
        push_exp(2'd1);
        send_byte("w", 1'b1);
        for (int k = na - 1; k >= 0; k--) send_byte(hexc(4'(a >> (4 * k))), 1'b1);
        send_byte(8'h20, 1'b1);
        for (int k = nd - 1; k >= 0; k--) send_byte(hexc(4'(d >> (4 * k))), 1'b1);
      end else begin
        push_exp(2'd2);
        send_byte("r", 1'b1);
        for (int k = na - 1; k >= 0; k--) send_byte(hexc(4'(a >> (4 * k))), 1'b1);
      end
      send_cr();
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_missing got=%0d exp=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rx_in   = 1'b1;
    reset_n = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_framing_glitch();
    test_upper();
    test_reset_mid();
    test_back_to_back();
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbgcmd.md
DBGCMD -- requirements
Module: dbgcmd

Interface
REQ-001 SHALL have parameter CLK_FRQ, default 27_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_in  input  1  UART 8N1 serial input from host, idle high.
REQ-006 SHALL have port cmd_addr  output  16  address of last accepted command.
REQ-007 SHALL have port cmd_wdata  output  16  data of last accepted write command.
REQ-008 SHALL have port cmd_we  output  1  one-cycle pulse, write command accepted.
REQ-009 SHALL have port cmd_re  output  1  one-cycle pulse, read command accepted.
REQ-010 SHALL have port cmd_err  output  1  one-cycle pulse, malformed line terminated.

Function
REQ-011 SHALL pass rx_in through a 2-FF synchronizer before any use.
REQ-012 SHALL use bit period DIV = CLK_FRQ/BAUD_RATE clocks (234 at defaults).
REQ-013 Receiver SHALL detect a start bit on a 1->0 synchronized edge while idle, recheck low at DIV/2, and return to idle if high (glitch).
REQ-014 Receiver SHALL sample 8 data bits LSB first at DIV intervals from the start mid-point, then the stop bit.
REQ-015 SHALL raise an internal byte-valid strobe for one cycle in the clock after the stop-bit sample; stop bit 0 = framing error: byte discarded, parser forced to ERR.
REQ-016 Parser states: IDLE, ADDR, DATA, ERR; hex digit = '0'-'9','a'-'f'; LF (0x0a) ignored in every state.
REQ-017 IDLE: 'w' -> ADDR op=write; 'r' -> ADDR op=read; addr/data accumulators and digit count cleared; space or CR stays IDLE; any other byte -> ERR.
REQ-018 ADDR: hex shifts accumulator left 4 (keeps last 4 digits); space with 0 digits ignored; space with >=1 digit -> DATA if write, ERR if read.
REQ-019 ADDR: CR with op=read and >=1 digit -> cmd_re pulse, IDLE; CR otherwise -> cmd_err pulse, IDLE; other byte -> ERR.
REQ-020 DATA: hex shifts data accumulator (last 4 kept); space with 0 digits ignored; CR with >=1 digit -> cmd_we pulse, IDLE; CR with 0 digits -> cmd_err, IDLE; other byte -> ERR.
REQ-021 ERR: all bytes discarded until CR, which gives cmd_err pulse and -> IDLE.
REQ-022 cmd_we/cmd_re/cmd_err SHALL assert exactly 1 cycle after the byte-valid strobe of the terminating CR; at most one of them per cycle.
REQ-023 cmd_addr (and cmd_wdata for writes) SHALL update in the same cycle the pulse asserts and hold until the next accepted command; fewer than 4 digits are zero-extended.
REQ-024 cmd_err SHALL NOT alter cmd_addr or cmd_wdata.

Reset
REQ-025 On reset_n low: cmd_addr=0, cmd_wdata=0, cmd_we=cmd_re=cmd_err=0, parser IDLE, receiver idle, synchronizer flops=1.
REQ-026 Reset mid-frame or mid-line SHALL abandon the partial byte/line with no output pulse.

Configuration
REQ-027 Macro DBGCMD_UPPER_EN defined: 'W','R','A'-'F' accepted equivalently to lowercase.
REQ-028 Macro DBGCMD_UPPER_EN undefined: uppercase letters are invalid bytes (-> ERR).

Verification
REQ-029 "w12 ab\r" -> one cmd_we pulse, cmd_addr=0x0012, cmd_wdata=0x00ab, no cmd_re/cmd_err.
REQ-030 "r1234\r\n" -> one cmd_re pulse, cmd_addr=0x1234, cmd_wdata unchanged; LF produces nothing.
REQ-031 "w123456 9abcd\r" -> cmd_we, cmd_addr=0x3456, cmd_wdata=0xabcd.
REQ-032 "x1\r", then "r\r", then "r12 3\r" -> three cmd_err pulses, cmd_addr stays at prior value.
REQ-033 Byte 'w' with stop bit 0, then "12 3\r" -> single cmd_err, no cmd_we; 1/4-bit start glitch -> no byte.
REQ-034 "W1F 0\r": with DBGCMD_UPPER_EN -> cmd_we, addr 0x001f; without -> cmd_err; reset_n low mid-"w12" then "\r" -> cmd_err not generated... CR alone from IDLE -> no pulse.
